// File: rtl/meas_pkg.sv
// rtl/meas_pkg.sv - shared types and result encodings for the measurement sequencer
package meas_pkg;

   localparam int COUNT_W_DEF = 23;

   // Result bus encodings understood by the blockade comparator.
   localparam logic [COUNT_W_DEF-1:0] NO_ECHO   = '1;
   localparam logic [COUNT_W_DEF-1:0] MEASURING = '0;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      WAIT_ECHO,
      GAP
   } meas_state_t;

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop synchroniser for the echo input with rising-edge pulse
module echo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic sync1, sync2, sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= async_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

endmodule

// File: rtl/measurement_sequencer.sv
// rtl/measurement_sequencer.sv - time-of-flight shot sequencer: trigger, echo count, timeout, gap
// Optional MEAS_AVG_EN: report the truncated mean of four consecutive shots.
module measurement_sequencer
   import meas_pkg::*;
#(
   parameter int COUNT_W        = COUNT_W_DEF,
   parameter int PULSE_CYCLES   = 500,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int GAP_CYCLES     = 100000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               cont_en,
   input  logic               echo_in,
   output logic               trig_out,
   output logic [COUNT_W-1:0] data_out,
   output logic               data_valid,
   output logic               busy,
   output logic               timeout
);

   localparam logic [COUNT_W-1:0] ALL_ONES     = '1;
   localparam logic [COUNT_W-1:0] ONE          = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] PULSE_LAST   = COUNT_W'(PULSE_CYCLES);
   localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES);
   localparam logic [COUNT_W-1:0] GAP_LAST     = COUNT_W'(GAP_CYCLES);

   meas_state_t        state, state_nx;
   logic [COUNT_W-1:0] count, count_nx, count_inc;
   logic [COUNT_W-1:0] data_nx;
   logic               trig_nx, valid_nx, timeout_nx;
   logic               echo_rise;
   logic               shot_done, shot_to;
   logic [COUNT_W-1:0] shot_val;
   logic               more_shots;

   echo_sync u_echo_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (echo_in),
      .rise     (echo_rise)
   );

   assign busy      = (state != IDLE);
   assign count_inc = (count == ALL_ONES) ? count : count + ONE;

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      trig_nx   = trig_out;
      shot_done = 1'b0;
      shot_to   = 1'b0;
      shot_val  = count;
      case (state)
         IDLE: begin
            count_nx = '0;
            if (start | cont_en) begin
               state_nx = PULSE;
               count_nx = ONE;
               trig_nx  = 1'b1;
            end
         end
         PULSE: begin
            count_nx = count_inc;
            if (count >= PULSE_LAST) begin
               state_nx = WAIT_ECHO;
               trig_nx  = 1'b0;
            end
         end
         WAIT_ECHO: begin
            count_nx = count_inc;
            // An edge arriving on the timeout cycle still counts as a real echo.
            if (echo_rise) begin
               shot_done = 1'b1;
            end else if (count >= TIMEOUT_LAST) begin
               shot_done = 1'b1;
               shot_val  = ALL_ONES;
               shot_to   = 1'b1;
            end
            if (shot_done) begin
               state_nx = GAP;
               count_nx = ONE;
            end
         end
         GAP: begin
            count_nx = count_inc;
            if (count >= GAP_LAST) begin
               if (cont_en | more_shots) begin
                  state_nx = PULSE;
                  count_nx = ONE;
                  trig_nx  = 1'b1;
               end else begin
                  state_nx = IDLE;
                  count_nx = '0;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            count_nx = '0;
            trig_nx  = 1'b0;
         end
      endcase
   end

`ifdef MEAS_AVG_EN
   logic [1:0]         shot_idx, shot_idx_nx;
   logic [COUNT_W+1:0] acc, acc_nx, acc_sum;
   logic               acc_to, acc_to_nx;

   assign acc_sum    = acc + {2'b00, shot_val};
   assign more_shots = (shot_idx != 2'd0);

   always_comb begin
      shot_idx_nx = shot_idx;
      acc_nx      = acc;
      acc_to_nx   = acc_to;
      valid_nx    = 1'b0;
      data_nx     = data_out;
      timeout_nx  = timeout;
      if (state == IDLE) begin
         shot_idx_nx = 2'd0;
         acc_nx      = '0;
         acc_to_nx   = 1'b0;
      end else if (shot_done) begin
         if (shot_idx == 2'd3) begin
            valid_nx    = 1'b1;
            data_nx     = COUNT_W'(acc_sum >> 2);
            timeout_nx  = acc_to | shot_to;
            shot_idx_nx = 2'd0;
            acc_nx      = '0;
            acc_to_nx   = 1'b0;
         end else begin
            shot_idx_nx = shot_idx + 2'd1;
            acc_nx      = acc_sum;
            acc_to_nx   = acc_to | shot_to;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shot_idx <= 2'd0;
         acc      <= '0;
         acc_to   <= 1'b0;
      end else begin
         shot_idx <= shot_idx_nx;
         acc      <= acc_nx;
         acc_to   <= acc_to_nx;
      end
   end
`else
   assign more_shots = 1'b0;

   always_comb begin
      valid_nx   = shot_done;
      data_nx    = shot_done ? shot_val : data_out;
      timeout_nx = shot_done ? shot_to : timeout;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         trig_out   <= 1'b0;
         data_out   <= COUNT_W'(MEASURING);
         data_valid <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         trig_out   <= trig_nx;
         data_out   <= data_nx;
         data_valid <= valid_nx;
         timeout    <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_measurement_sequencer.sv
// tb/tb_measurement_sequencer.sv - self-checking bench for measurement_sequencer
module tb_measurement_sequencer;

   localparam int W  = 23;
   localparam int PC = 4;
   localparam int TC = 64;
   localparam int GC = 8;
`ifdef MEAS_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         cont_en = 1'b0;
   logic         echo_in = 1'b0;
   logic         trig_out, data_valid, busy, timeout;
   logic [W-1:0] data_out;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] last_val = '0;
   logic         last_to = 1'b0;
   int           avg_n = 0;
   longint       avg_sum = 0;
   logic         avg_to = 1'b0;

   always #5 clk = ~clk;

   measurement_sequencer #(
      .COUNT_W        (W),
      .PULSE_CYCLES   (PC),
      .TIMEOUT_CYCLES (TC),
      .GAP_CYCLES     (GC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cont_en    (cont_en),
      .echo_in    (echo_in),
      .trig_out   (trig_out),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .timeout    (timeout)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Echo driven d cycles after the trigger edge is seen at count d+1 plus two sync stages.
   function automatic void shot_model(input int d, output int kv, output logic [W-1:0] val,
                                      output logic to);
      int c;
      c = d + 3;
      if (c > PC && c <= TC) begin
         kv  = c;
         val = W'(c);
         to  = 1'b0;
      end else begin
         kv  = TC;
         val = '1;
         to  = 1'b1;
      end
   endfunction

   // Entered one time unit after the edge that raised trig_out; leaves at the next shot's start.
   task automatic run_shot(input int d, input bit glitch, input bit gap_start, input int drop_at);
      int           kv;
      logic [W-1:0] val;
      logic         to;
      logic         report;
      logic         more;
      shot_model(d, kv, val, to);
      report = 1'b1;
      if (AVG) begin
         avg_sum += longint'(val);
         avg_to  |= to;
         avg_n++;
         report = (avg_n == 4);
         if (report) begin
            val     = W'(avg_sum >> 2);
            to      = avg_to;
            avg_sum = 0;
            avg_n   = 0;
            avg_to  = 1'b0;
         end
      end
      for (int k = 0; k < kv + GC; k++) begin
         if (k == kv && report) begin
            last_val = val;
            last_to  = to;
         end
         check1("trig", trig_out, k < PC);
         check1("busy", busy, 1'b1);
         check1("valid", data_valid, k == kv && report);
         checkw("data", data_out, last_val);
         check1("timeout", timeout, last_to);
         if (glitch && k == 0) echo_in = 1'b1;
         if (glitch && k == 2) echo_in = 1'b0;
         if (k == d) echo_in = 1'b1;
         if (k == kv) echo_in = 1'b0;
         if (glitch && d < kv && k == kv + 2) echo_in = 1'b1;
         if (glitch && d < kv && k == kv + 4) echo_in = 1'b0;
         if (gap_start) start = (k == kv + 3);
         if (k == drop_at) cont_en = 1'b0;
         @(posedge clk); #1;
      end
      echo_in = 1'b0;
      start   = 1'b0;
      more    = cont_en || (AVG && avg_n != 0);
      check1("next_trig", trig_out, more);
      check1("next_busy", busy, more);
   endtask

   task automatic finish_avg(input int d);
      int i;
      i = 1;
      while (AVG && avg_n != 0 && i < 4) begin
         run_shot(d + 4 * i, 1'b0, 1'b0, -1);
         i++;
      end
   endtask

   task automatic single(input int d, input bit glitch, input bit gap_start);
      check1("idle_trig", trig_out, 1'b0);
      check1("idle_busy", busy, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_shot(d, glitch, gap_start, -1);
      finish_avg(d);
   endtask

   task automatic reset_at(input int k_at);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (k_at) @(posedge clk);
      #1;
      check1("pre_rst_busy", busy, 1'b1);
      check1("pre_rst_trig", trig_out, k_at < PC);
      rst_n   = 1'b0;
      cont_en = 1'b0;
      echo_in = 1'b0;
      #1;
      check1("rst_trig", trig_out, 1'b0);
      check1("rst_busy", busy, 1'b0);
      checkw("rst_data", data_out, '0);
      check1("rst_valid", data_valid, 1'b0);
      check1("rst_timeout", timeout, 1'b0);
      last_val = '0;
      last_to  = 1'b0;
      avg_n    = 0;
      avg_sum  = 0;
      avg_to   = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check1("post_rst_busy", busy, 1'b0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check1("reset_trig", trig_out, 1'b0);
      check1("reset_busy", busy, 1'b0);
      checkw("reset_data", data_out, '0);
      check1("reset_valid", data_valid, 1'b0);
      check1("reset_timeout", timeout, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check1("idle_after_reset", busy, 1'b0);

      single(20, 1'b0, 1'b0);
      single(100, 1'b0, 1'b0);
      single(20, 1'b1, 1'b1);
      single(61, 1'b0, 1'b0);
      single(62, 1'b0, 1'b0);
      single(2, 1'b0, 1'b0);
      single(1, 1'b0, 1'b0);
      single(10, 1'b0, 1'b0);

      cont_en = 1'b1;
      @(posedge clk); #1;
      run_shot(10, 1'b0, 1'b0, -1);
      run_shot(10, 1'b0, 1'b1, -1);
      run_shot(10, 1'b0, 1'b0, 5);
      finish_avg(10);
      repeat (3) @(posedge clk);
      #1;
      check1("cont_stopped", busy, 1'b0);

      for (int n = 0; n < 12; n++) begin
         single(int'($urandom_range(0, 70)), 1'b0, 1'b0);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end

      reset_at(2);
      single(20, 1'b0, 1'b0);
      reset_at(10);
      single(15, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
